// File: rtl/jogo_unidade_controle.sv
// Moore control unit for the memory-game datapath: sequences preparation,
// per-jogada register/compare steps and the three end states.
module jogo_unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       igual,
  input  logic       fimC,
  input  logic       jogada_feita,
  input  logic       timeout,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registrarR,
  output logic       zera_s_timeout,
  output logic       enable_timeout,
  output logic       registra_modo,
  output logic       zera_modo,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'b0000,
    PREPARACAO    = 4'b0001,
    ESPERA_JOGADA = 4'b0010,
    REGISTRA      = 4'b0100,
    COMPARACAO    = 4'b0101,
    PROXIMO       = 4'b0110,
    FIM_ACERTO    = 4'b1010,
    FIM_TIMEOUT   = 4'b1101,
    FIM_ERRO      = 4'b1110
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = INICIAL;
    case (state_q)
      INICIAL:       state_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:    state_d = ESPERA_JOGADA;
      // A key press in the same cycle as the terminal count still counts as a jogada.
      ESPERA_JOGADA: begin
        if (jogada_feita) state_d = REGISTRA;
        else if (timeout) state_d = FIM_TIMEOUT;
        else              state_d = ESPERA_JOGADA;
      end
      REGISTRA:      state_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)    state_d = FIM_ERRO;
        else if (fimC) state_d = FIM_ACERTO;
        else           state_d = PROXIMO;
      end
      PROXIMO:       state_d = ESPERA_JOGADA;
      FIM_ACERTO:    state_d = iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_ERRO:      state_d = iniciar ? PREPARACAO : FIM_ERRO;
      FIM_TIMEOUT:   state_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
      default:       state_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraC          = 1'b0;
    contaC         = 1'b0;
    zeraR          = 1'b0;
    registrarR     = 1'b0;
    zera_s_timeout = 1'b0;
    enable_timeout = 1'b0;
    registra_modo  = 1'b0;
    zera_modo      = 1'b0;
    pronto         = 1'b0;
    acertou        = 1'b0;
    errou          = 1'b0;
    db_timeout     = 1'b0;
    case (state_q)
      INICIAL: begin
        zeraC          = 1'b1;
        zeraR          = 1'b1;
        zera_modo      = 1'b1;
        zera_s_timeout = 1'b1;
      end
      PREPARACAO: begin
        zeraC          = 1'b1;
        zeraR          = 1'b1;
        registra_modo  = 1'b1;
        zera_s_timeout = 1'b1;
      end
      ESPERA_JOGADA: enable_timeout = 1'b1;
      // Clearing the timeout here gives every jogada a full window.
      REGISTRA: begin
        registrarR     = 1'b1;
        zera_s_timeout = 1'b1;
      end
      PROXIMO: contaC = 1'b1;
      FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      FIM_TIMEOUT: begin
        pronto     = 1'b1;
        errou      = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule

// File: tb/tb_jogo_unidade_controle.sv
// Directed bench for jogo_unidade_controle: full game, wrong jogada, timeout,
// simultaneous events, restart and asynchronous reset.
module tb_jogo_unidade_controle;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, igual, fimC, jogada_feita, timeout;
  logic       zeraC, contaC, zeraR, registrarR, zera_s_timeout, enable_timeout;
  logic       registra_modo, zera_modo, pronto, acertou, errou, db_timeout;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_fails  = 0;
  int conta_cnt = 0;

  // Output vector order:
  // {zeraC,contaC,zeraR,registrarR,zera_s_timeout,enable_timeout,
  //  registra_modo,zera_modo,pronto,acertou,errou,db_timeout}
  localparam logic [11:0] O_INICIAL  = 12'b1010_1001_0000;
  localparam logic [11:0] O_PREP     = 12'b1010_1010_0000;
  localparam logic [11:0] O_ESPERA   = 12'b0000_0100_0000;
  localparam logic [11:0] O_REGISTRA = 12'b0001_1000_0000;
  localparam logic [11:0] O_COMPARA  = 12'b0000_0000_0000;
  localparam logic [11:0] O_PROXIMO  = 12'b0100_0000_0000;
  localparam logic [11:0] O_ACERTO   = 12'b0000_0000_1100;
  localparam logic [11:0] O_ERRO     = 12'b0000_0000_1010;
  localparam logic [11:0] O_TIMEOUT  = 12'b0000_0000_1011;

  wire [11:0] outs = {zeraC, contaC, zeraR, registrarR, zera_s_timeout, enable_timeout,
                      registra_modo, zera_modo, pronto, acertou, errou, db_timeout};

  jogo_unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual), .fimC(fimC),
    .jogada_feita(jogada_feita), .timeout(timeout),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registrarR(registrarR),
    .zera_s_timeout(zera_s_timeout), .enable_timeout(enable_timeout),
    .registra_modo(registra_modo), .zera_modo(zera_modo), .pronto(pronto),
    .acertou(acertou), .errou(errou), .db_timeout(db_timeout), .db_estado(db_estado)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] st, input logic [11:0] o);
    check({tag, "_estado"}, {8'h0, db_estado}, {8'h0, st});
    check({tag, "_outs"}, outs, o);
  endtask

  // One rising edge; outputs settle 1ns later, away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (contaC === 1'b1) conta_cnt++;
  endtask

  // From espera_jogada: press, register, compare with the given igual/fimC.
  task automatic play(input string tag, input logic ig, input logic fc);
    jogada_feita = 1'b1;
    tick();
    jogada_feita = 1'b0;
    check_state({tag, "_reg"}, 4'b0100, O_REGISTRA);
    tick();
    check_state({tag, "_cmp"}, 4'b0101, O_COMPARA);
    igual = ig;
    fimC  = fc;
    tick();
    igual = 1'b0;
    fimC  = 1'b0;
    if (ig && !fc) begin
      check_state({tag, "_prox"}, 4'b0110, O_PROXIMO);
      tick();
      check_state({tag, "_esp"}, 4'b0010, O_ESPERA);
    end
  endtask

  task automatic start(input string tag);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check_state({tag, "_prep"}, 4'b0001, O_PREP);
    tick();
    check_state({tag, "_esp"}, 4'b0010, O_ESPERA);
  endtask

  initial begin
    reset = 1'b0;
    iniciar = 1'b0; igual = 1'b0; fimC = 1'b0; jogada_feita = 1'b0; timeout = 1'b0;
    #3;
    check_state("reset", 4'b0000, O_INICIAL);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state("idle", 4'b0000, O_INICIAL);
    end

    // Full correct game of four jogadas
    start("g1");
    conta_cnt = 0;
    play("g1j1", 1'b1, 1'b0);
    play("g1j2", 1'b1, 1'b0);
    // iniciar is ignored while waiting for a jogada
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    check_state("ign_iniciar", 4'b0010, O_ESPERA);
    play("g1j3", 1'b1, 1'b0);
    play("g1j4", 1'b1, 1'b1);
    check_state("acerto", 4'b1010, O_ACERTO);
    tick(); tick();
    check_state("acerto_hold", 4'b1010, O_ACERTO);
    check("conta_g1", 12'(conta_cnt), 12'd3);

    // Wrong jogada at the second comparison
    start("g2");
    conta_cnt = 0;
    play("g2j1", 1'b1, 1'b0);
    play("g2j2", 1'b0, 1'b0);
    check_state("erro", 4'b1110, O_ERRO);
    tick();
    check_state("erro_hold", 4'b1110, O_ERRO);
    check("conta_g2", 12'(conta_cnt), 12'd1);

    // Restart from fim_erro, then timeout
    start("g3");
    tick(); tick(); tick();
    check_state("wait_esp", 4'b0010, O_ESPERA);
    timeout = 1'b1;
    tick();
    timeout = 1'b0;
    check_state("timeout", 4'b1101, O_TIMEOUT);
    tick();
    check_state("timeout_hold", 4'b1101, O_TIMEOUT);

    // Simultaneous jogada_feita and timeout: the jogada wins
    start("g4");
    jogada_feita = 1'b1;
    timeout = 1'b1;
    tick();
    jogada_feita = 1'b0;
    timeout = 1'b0;
    check_state("simul", 4'b0100, O_REGISTRA);
    tick();
    check_state("pre_rst", 4'b0101, O_COMPARA);

    // Asynchronous reset mid-cycle in comparacao
    #2;
    reset = 1'b0;
    #1;
    check_state("async_rst", 4'b0000, O_INICIAL);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check_state("post_rst", 4'b0000, O_INICIAL);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/jogo_unidade_controle.md
Name: jogo_unidade_controle

Overview:
- Control unit (Moore FSM) for the memory-game datapath.
- Consumes the datapath status signals (igual, fimC, jogada_feita, timeout) and drives its control inputs: counter, registers, timeout counter and mode register.
- Sits directly beside the datapath in the top level; the top-level start input and game result outputs connect here.

Parameters:
- none (state encoding is fixed because it is exported on db_estado)

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; forces state inicial
- iniciar  in  1  start/restart request, level-sampled
- igual  in  1  datapath: registered jogada equals memory data
- fimC  in  1  datapath: last jogada of the selected mode reached
- jogada_feita  in  1  datapath: 1-cycle pulse, new key press
- timeout  in  1  datapath: timeout counter terminal count
- zeraC  out  1  clear address counter
- contaC  out  1  increment address counter
- zeraR  out  1  clear jogada register
- registrarR  out  1  load jogada register
- zera_s_timeout  out  1  synchronous clear of timeout counter
- enable_timeout  out  1  timeout counter count enable
- registra_modo  out  1  load mode register
- zera_modo  out  1  clear mode register
- pronto  out  1  game finished (any outcome)
- acertou  out  1  finished, all jogadas correct
- errou  out  1  finished by wrong jogada or timeout
- db_timeout  out  1  finished by timeout
- db_estado  out  4  current state code

Behaviour:
- State register is 4 bits and reset asynchronously by reset=0 to inicial.
- All outputs are decoded combinationally from the state register only (pure Moore). Any output not listed for a state is 0.
- State codes:
  - inicial=0000, preparacao=0001, espera_jogada=0010, registra=0100, comparacao=0101, proximo=0110
  - fim_acerto=1010, fim_erro=1110, fim_timeout=1101
  - unused codes go to inicial on the next edge
- inicial:
  - outputs: zeraC, zeraR, zera_modo, zera_s_timeout = 1
  - iniciar=1 -> preparacao; otherwise stay
- preparacao:
  - outputs: zeraC, zeraR, registra_modo, zera_s_timeout = 1
  - unconditionally -> espera_jogada
- espera_jogada:
  - output: enable_timeout=1
  - jogada_feita=1 -> registra; this has priority when timeout=1 in the same cycle
  - else timeout=1 -> fim_timeout
  - else stay
- registra:
  - outputs: registrarR=1, zera_s_timeout=1
  - -> comparacao
- comparacao (no outputs asserted):
  - igual=0 -> fim_erro
  - igual=1 and fimC=1 -> fim_acerto
  - igual=1 and fimC=0 -> proximo
- proximo:
  - output: contaC=1
  - -> espera_jogada
- fim_acerto: pronto=1, acertou=1
- fim_erro: pronto=1, errou=1
- fim_timeout: pronto=1, errou=1, db_timeout=1
- All three end states: iniciar=1 -> preparacao (restart; the counter, jogada register and mode register are re-initialised there); otherwise hold.
- Latency:
  - jogada_feita pulse to comparacao: 2 edges
  - comparacao to the next espera_jogada: 2 edges
  - the timeout counter is cleared once per jogada (in registra), so each jogada gets a full timeout window
- iniciar is ignored in every state other than inicial and the end states.
- Reset mid-operation: with reset=0, state is inicial immediately (no clock needed), and outputs show inicial values during reset.
- db_estado always equals the current state code.

Test Plan:
- Reset then idle: reset=0 -> db_estado=0000, zeraC=zeraR=zera_modo=zera_s_timeout=1, pronto=0. Release reset, iniciar=0 for 5 cycles -> db_estado stays 0000.
- Full correct game: iniciar=1 for 1 cycle, then 4 jogada_feita pulses with igual=1; fimC=1 on the 4th comparison only -> states 0001,0010,0100,0101,0110 repeat, contaC asserted exactly 3 times, final db_estado=1010 with pronto=acertou=1 held.
- Wrong jogada: igual=0 at the 2nd comparison -> db_estado=1110, pronto=errou=1, db_timeout=0; contaC asserted exactly once.
- Timeout: remain in espera_jogada with no jogada_feita, then pulse timeout=1 -> next edge db_estado=1101, pronto=errou=db_timeout=1.
- Simultaneous events: jogada_feita=1 and timeout=1 in the same espera_jogada cycle -> next state 0100 (registra), not 1101.
- Restart and async reset: from 1110 assert iniciar -> 0001 with zeraC=registra_modo=1. Drive reset=0 mid-cycle while in 0101 -> db_estado=0000 before the next clock edge.
